// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, condition codes,
// shift types, flag bit positions, FSM states and condition evaluation.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd = 4'h0, OpOr  = 4'h1, OpXor = 4'h2, OpNot = 4'h3,
    OpAdd = 4'h4, OpAdc = 4'h5, OpSub = 4'h6, OpSbc = 4'h7,
    OpMul = 4'h8, OpMov = 4'h9, OpTst = 4'hA, OpCmp = 4'hB,
    OpCmn = 4'hC, OpBic = 4'hD, OpRsb = 4'hE, OpRsv = 4'hF
  } op_e;

  typedef enum logic [3:0] {
    CcEq = 4'h0, CcNe = 4'h1, CcCs = 4'h2, CcCc = 4'h3,
    CcMi = 4'h4, CcPl = 4'h5, CcVs = 4'h6, CcVc = 4'h7,
    CcHi = 4'h8, CcLs = 4'h9, CcGe = 4'hA, CcLt = 4'hB,
    CcGt = 4'hC, CcLe = 4'hD, CcAl = 4'hE, CcNv = 4'hF
  } cond_e;

  typedef enum logic [2:0] {
    SrNone = 3'd0, SrLsl = 3'd1, SrLsr = 3'd2, SrAsr = 3'd3, SrRor = 3'd4
  } sr_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  // ARM-style condition test against an NZCV flag vector.
  function automatic logic cond_check(logic [3:0] cond, logic [3:0] flags);
    logic n, z, c, v, res;
    n   = flags[FlagN];
    z   = flags[FlagZ];
    c   = flags[FlagC];
    v   = flags[FlagV];
    res = 1'b0;
    unique case (cond_e'(cond))
      CcEq: res = z;
      CcNe: res = !z;
      CcCs: res = c;
      CcCc: res = !c;
      CcMi: res = n;
      CcPl: res = !n;
      CcVs: res = v;
      CcVc: res = !v;
      CcHi: res = c && !z;
      CcLs: res = !c || z;
      CcGe: res = (n == v);
      CcLt: res = (n != v);
      CcGt: res = !z && (n == v);
      CcLe: res = z || (n != v);
      CcAl: res = 1'b1;
      CcNv: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the second operand, with shifter carry-out.
module alu_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [SW-1:0]    i_amt,
  input  logic [2:0]       i_type,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_val,
  output logic             o_carry
);
  import alu_pkg::*;

  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_ror;

  // Candidate shifts; the extra bit captures the last bit shifted out.
  always_comb begin
    w_lsl   = {1'b0, i_val} << i_amt;
    w_lsr   = {i_val, 1'b0} >> i_amt;
    w_asr   = $unsigned($signed({i_val, 1'b0}) >>> i_amt);
    w_ror   = (i_val >> i_amt) | (i_val << (WIDTH - 32'(i_amt)));
    o_val   = i_val;
    o_carry = i_carry;
    // A zero amount passes the operand and the current carry through.
    if (i_amt != '0) begin
      case (i_type)
        SrLsl: begin o_val = w_lsl[WIDTH-1:0]; o_carry = w_lsl[WIDTH]; end
        SrLsr: begin o_val = w_lsr[WIDTH:1];   o_carry = w_lsr[0];     end
        SrAsr: begin o_val = w_asr[WIDTH:1];   o_carry = w_asr[0];     end
        SrRor: begin o_val = w_ror;            o_carry = w_ror[WIDTH-1]; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, iterative shift-add multiply,
// conditional execution against a registered NZCV flag register.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Opcode,
  input  logic [3:0]       Cond,
  input  logic             S,
  input  logic [2:0]       SR_Cont,
  input  logic [SW-1:0]    SR_Bit,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Cond_Pass,
  output logic [3:0]       Flags
);
  import alu_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_pass, w_pass_nxt;
  logic [3:0]       r_flags, w_flags_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_mul_s, w_mul_s_nxt;
  logic             r_alive;

  op_e              w_op;
  logic [WIDTH-1:0] w_sh_val;
  logic             w_sh_c;
  logic             w_pass;
  logic [WIDTH-1:0] w_add_x, w_add_y;
  logic             w_add_ci, w_add_v;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_arith, w_logic, w_wb, w_force;
  logic [3:0]       w_flags_op;

  assign w_op   = op_e'(Opcode);
  assign w_pass = cond_check(Cond, r_flags);

  alu_shifter #(
    .WIDTH(WIDTH),
    .SW   (SW)
  ) u_shifter (
    .i_val  (In2),
    .i_amt  (SR_Bit),
    .i_type (SR_Cont),
    .i_carry(r_flags[FlagC]),
    .o_val  (w_sh_val),
    .o_carry(w_sh_c)
  );

  // Shared adder: subtraction forms feed the inverted operand with carry-in.
  always_comb begin
    w_add_x  = In1;
    w_add_y  = w_sh_val;
    w_add_ci = 1'b0;
    case (w_op)
      OpAdc:        w_add_ci = r_flags[FlagC];
      OpSub, OpCmp: begin w_add_y = ~w_sh_val; w_add_ci = 1'b1; end
      OpSbc:        begin w_add_y = ~w_sh_val; w_add_ci = r_flags[FlagC]; end
      OpRsb:        begin w_add_x = w_sh_val; w_add_y = ~In1; w_add_ci = 1'b1; end
      default: ;
    endcase
    w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_ci};
    w_add_v = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);
  end

  // Single-cycle result, writeback enable and the flags that op would produce.
  always_comb begin
    w_res   = '0;
    w_arith = 1'b0;
    w_logic = 1'b0;
    w_wb    = 1'b1;
    w_force = 1'b0;
    unique case (w_op)
      OpAnd, OpTst: begin w_res = In1 & w_sh_val;  w_logic = 1'b1; end
      OpOr:         begin w_res = In1 | w_sh_val;  w_logic = 1'b1; end
      OpXor:        begin w_res = In1 ^ w_sh_val;  w_logic = 1'b1; end
      OpNot:        begin w_res = ~w_sh_val;       w_logic = 1'b1; end
      OpMov:        begin w_res = w_sh_val;        w_logic = 1'b1; end
      OpBic:        begin w_res = In1 & ~w_sh_val; w_logic = 1'b1; end
      OpAdd, OpAdc, OpSub, OpSbc, OpRsb, OpCmp, OpCmn: begin
        w_res   = w_sum[WIDTH-1:0];
        w_arith = 1'b1;
      end
      OpMul: ;
      OpRsv: w_wb = 1'b0;
    endcase
    // Compare-type ops always set flags and never write a result.
    if (w_op inside {OpTst, OpCmp, OpCmn}) begin
      w_wb    = 1'b0;
      w_force = 1'b1;
    end
    w_flags_op = r_flags;
    if (w_arith) begin
      w_flags_op = {w_res[WIDTH-1], (w_res == '0), w_sum[WIDTH], w_add_v};
    end else if (w_logic) begin
      w_flags_op = {w_res[WIDTH-1], (w_res == '0), w_sh_c, r_flags[FlagV]};
    end
  end

  assign In_Ready  = r_alive && ((r_state == StIdle) || ((r_state == StDone) && Out_Ready));
  assign Out_Valid = (r_state == StDone);
  assign Out       = r_out;
  assign Cond_Pass = r_pass;
  assign Flags     = r_flags;

  // Next state: multiply iteration, output hold, and acceptance of a new request.
  always_comb begin
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_pass_nxt   = r_pass;
    w_flags_nxt  = r_flags;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_mul_s_nxt  = r_mul_s;
    unique case (r_state)
      StIdle: ;
      StMul: begin
        if (r_cnt == CW'(WIDTH)) begin
          w_state_nxt = StDone;
          w_out_nxt   = r_acc;
          if (r_mul_s) begin
            w_flags_nxt[FlagN] = r_acc[WIDTH-1];
            w_flags_nxt[FlagZ] = (r_acc == '0);
          end
        end else begin
          if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = r_mplier >> 1;
          w_cnt_nxt    = r_cnt + CW'(1);
        end
      end
      StDone: if (Out_Ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (In_Valid && In_Ready) begin
      w_pass_nxt  = w_pass;
      w_state_nxt = StDone;
      if (!w_pass) begin
        w_out_nxt = '0;
      end else if (w_op == OpMul) begin
        w_state_nxt  = StMul;
        w_acc_nxt    = '0;
        w_mcand_nxt  = In1;
        w_mplier_nxt = w_sh_val;
        w_cnt_nxt    = '0;
        w_mul_s_nxt  = S;
      end else begin
        w_out_nxt = w_wb ? w_res : '0;
        if (S || w_force) w_flags_nxt = w_flags_op;
      end
    end
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= StIdle;
      r_out    <= '0;
      r_pass   <= 1'b0;
      r_flags  <= 4'b0000;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_mul_s  <= 1'b0;
      r_alive  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_pass   <= w_pass_nxt;
      r_flags  <= w_flags_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mul_s  <= w_mul_s_nxt;
      r_alive  <= 1'b1;
    end
  end

endmodule
